lic_mtimer_multi: RTL and testbench

//  Parametrised local-interrupt timer for the cpu6 SoC. It has one shared free-running mtime

---
 rtl/lic_mtimer_multi.sv | 165 ++++++++++++++++
 tb/tb_lic_mtimer_multi.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lic_mtimer_multi.sv
// Local-interrupt timer: shared prescaled mtime counter with NUM_CH sticky compare channels.
// Optional per-channel auto-reload of CMP is built when LIC_AUTORELOAD_EN is defined.
module lic_mtimer_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lic_cs,
    input  logic              lic_we,
    input  logic [7:0]        lic_addr,
    input  logic [31:0]       lic_wdata,
    output logic [31:0]       lic_rdata,
    output logic              lic_timer_interrupt,
    output logic [NUM_CH-1:0] lic_irq_vec
);

    localparam logic [5:0] A_CTRL   = 6'd0;
    localparam logic [5:0] A_MTIME  = 6'd1;
    localparam logic [5:0] A_PEND   = 6'd2;
    localparam logic [5:0] A_EN     = 6'd3;
    localparam int         CMP_BASE = 4;
    localparam int         RLD_BASE = 16;

    logic               run_q, run_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   mtime_q, mtime_d, mtime_inc;
    logic [NUM_CH-1:0]  pend_q, pend_d;
    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  match;
    logic [CNT_W-1:0]   cmp_q [NUM_CH];
    logic [CNT_W-1:0]   cmp_d [NUM_CH];
`ifdef LIC_AUTORELOAD_EN
    logic [CNT_W-1:0]   reload_q [NUM_CH];
    logic [CNT_W-1:0]   reload_d [NUM_CH];
`endif
    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q;
    logic [NUM_CH-1:0]  vec_q;
    logic               tick;

    logic [5:0] widx;
    logic       wr_en, rd_en;
    logic       wr_ctrl, wr_mtime, wr_pend, wr_en_reg;
    logic       unused_addr_lsb;

    assign widx            = lic_addr[7:2];
    assign unused_addr_lsb = ^lic_addr[1:0];
    assign wr_en           = lic_cs & lic_we;
    assign rd_en           = lic_cs & ~lic_we;
    assign wr_ctrl         = wr_en && (widx == A_CTRL);
    assign wr_mtime        = wr_en && (widx == A_MTIME);
    assign wr_pend         = wr_en && (widx == A_PEND);
    assign wr_en_reg       = wr_en && (widx == A_EN);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        tick      = run_q && (pcnt_q == presc_q);
        mtime_inc = mtime_q + CNT_W'(1);

        run_d   = run_q;
        presc_d = presc_q;
        if (wr_ctrl) begin
            run_d   = lic_wdata[0];
            presc_d = lic_wdata[8 +: PRESC_W];
        end

        pcnt_d = pcnt_q;
        if (wr_ctrl)    pcnt_d = '0;
        else if (run_q) pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);

        mtime_d = mtime_q;
        if (wr_mtime)  mtime_d = lic_wdata[CNT_W-1:0];
        else if (tick) mtime_d = mtime_inc;

        // A bus write to MTIME replaces the increment, so no transition into CMP happens.
        for (int i = 0; i < NUM_CH; i++) begin
            match[i] = tick && !wr_mtime && (mtime_inc == cmp_q[i]);
        end

        pend_d = pend_q;
        if (wr_pend) pend_d = pend_q & ~lic_wdata[NUM_CH-1:0];
        pend_d = pend_d | match;

        en_d = en_q;
        if (wr_en_reg) en_d = lic_wdata[NUM_CH-1:0];

        for (int i = 0; i < NUM_CH; i++) begin
            cmp_d[i] = cmp_q[i];
`ifdef LIC_AUTORELOAD_EN
            reload_d[i] = reload_q[i];
            if (match[i]) cmp_d[i] = cmp_q[i] + reload_q[i];
            if (wr_en && (widx == 6'(RLD_BASE + i))) reload_d[i] = lic_wdata[CNT_W-1:0];
`endif
            if (wr_en && (widx == 6'(CMP_BASE + i))) cmp_d[i] = lic_wdata[CNT_W-1:0];
        end

        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            case (widx)
                A_CTRL: begin
                    rdata_d[0]            = run_q;
                    rdata_d[8 +: PRESC_W] = presc_q;
                end
                A_MTIME: rdata_d[CNT_W-1:0]  = mtime_q;
                A_PEND:  rdata_d[NUM_CH-1:0] = pend_q;
                A_EN:    rdata_d[NUM_CH-1:0] = en_q;
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (widx == 6'(CMP_BASE + i)) rdata_d[CNT_W-1:0] = cmp_q[i];
`ifdef LIC_AUTORELOAD_EN
                        if (widx == 6'(RLD_BASE + i)) rdata_d[CNT_W-1:0] = reload_q[i];
`endif
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q   <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            mtime_q <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            // NOTE: the small CMP/RELOAD arrays are flops, not RAM, so they reset like any register.
            for (int i = 0; i < NUM_CH; i++) begin
                cmp_q[i] <= '0;
`ifdef LIC_AUTORELOAD_EN
                reload_q[i] <= '0;
`endif
            end
        end else begin
            run_q   <= run_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
            pend_q  <= pend_d;
            en_q    <= en_d;
            rdata_q <= rdata_d;
            irq_q   <= |(pend_q & en_q);
            vec_q   <= pend_q & en_q;
            for (int i = 0; i < NUM_CH; i++) begin
                cmp_q[i] <= cmp_d[i];
`ifdef LIC_AUTORELOAD_EN
                reload_q[i] <= reload_d[i];
`endif
            end
        end
    end

    assign lic_rdata           = rdata_q;
    assign lic_timer_interrupt = irq_q;
    assign lic_irq_vec         = vec_q;

endmodule

// File: tb/tb_lic_mtimer_multi.sv
// Self-checking bench for lic_mtimer_multi: directed scenarios plus random bus traffic
// compared cycle by cycle against a behavioural model of the timer.
module tb_lic_mtimer_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int PRESC_W = 8;
    localparam logic [31:0] CMASK = 32'((64'(1) << CNT_W) - 1);

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              lic_cs = 1'b0;
    logic              lic_we = 1'b0;
    logic [7:0]        lic_addr = '0;
    logic [31:0]       lic_wdata = '0;
    logic [31:0]       lic_rdata;
    logic              lic_timer_interrupt;
    logic [NUM_CH-1:0] lic_irq_vec;

    always #5 clk = ~clk;

    lic_mtimer_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .lic_cs              (lic_cs),
        .lic_we              (lic_we),
        .lic_addr            (lic_addr),
        .lic_wdata           (lic_wdata),
        .lic_rdata           (lic_rdata),
        .lic_timer_interrupt (lic_timer_interrupt),
        .lic_irq_vec         (lic_irq_vec)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit                m_run;
    int                m_presc;
    int                m_div;
    logic [31:0]       m_mtime;
    logic [NUM_CH-1:0] m_pend, m_en, m_vec;
    logic [31:0]       m_cmp [NUM_CH];
    logic [31:0]       m_reload [NUM_CH];
    logic [31:0]       m_rdata;
    bit                m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_presc = 0; m_div = 0; m_mtime = 0;
        m_pend = 0; m_en = 0; m_vec = 0; m_rdata = 0; m_irq = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_cmp[i] = 0;
            m_reload[i] = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int w;
        logic [31:0] r;
        w = int'(a[7:2]);
        r = 0;
        if (w == 0) begin
            r[0] = m_run;
            r[8 +: PRESC_W] = PRESC_W'(m_presc);
        end else if (w == 1) r = m_mtime;
        else if (w == 2) r = 32'(m_pend);
        else if (w == 3) r = 32'(m_en);
        else if (w >= 4 && w < 4 + NUM_CH) r = m_cmp[w-4];
`ifdef LIC_AUTORELOAD_EN
        else if (w >= 16 && w < 16 + NUM_CH) r = m_reload[w-16];
`endif
        return r;
    endfunction

    // Advance the model by one clock using the bus inputs currently presented.
    task automatic m_step();
        int w;
        bit wr, rd, tick;
        logic [31:0] nxt;
        logic [NUM_CH-1:0] hit;
        w    = int'(lic_addr[7:2]);
        wr   = lic_cs && lic_we;
        rd   = lic_cs && !lic_we;
        tick = m_run && (m_div == m_presc);
        nxt  = (m_mtime + 1) & CMASK;
        hit  = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (tick && !(wr && w == 1) && nxt == m_cmp[i]) hit[i] = 1'b1;
        if (rd) m_rdata = m_read(lic_addr);
        m_vec = m_pend & m_en;
        m_irq = |m_vec;
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef LIC_AUTORELOAD_EN
            if (hit[i]) m_cmp[i] = (m_cmp[i] + m_reload[i]) & CMASK;
            if (wr && w == 16 + i) m_reload[i] = lic_wdata & CMASK;
`endif
            if (wr && w == 4 + i) m_cmp[i] = lic_wdata & CMASK;
        end
        if (wr && w == 2) m_pend = m_pend & ~lic_wdata[NUM_CH-1:0];
        m_pend = m_pend | hit;
        if (wr && w == 3) m_en = lic_wdata[NUM_CH-1:0];
        if (wr && w == 1) m_mtime = lic_wdata & CMASK;
        else if (tick) m_mtime = nxt;
        if (wr && w == 0) m_div = 0;
        else if (m_run) m_div = tick ? 0 : m_div + 1;
        if (wr && w == 0) begin
            m_run   = lic_wdata[0];
            m_presc = int'(lic_wdata[8 +: PRESC_W]);
        end
    endtask

    task automatic cycle();
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        lic_cs = 0; lic_we = 0;
        repeat (n) cycle();
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        lic_cs = 1; lic_we = 1; lic_addr = a; lic_wdata = d;
        cycle();
        lic_cs = 0; lic_we = 0;
    endtask

    task automatic bus_rd(input string tag, input logic [7:0] a, output logic [31:0] v);
        lic_cs = 1; lic_we = 0; lic_addr = a;
        cycle();
        lic_cs = 0;
        v = lic_rdata;
        check(tag, lic_rdata, m_rdata);
    endtask

    task automatic check_out(input string tag);
        check({tag, "_irq"}, 32'(lic_timer_interrupt), 32'(m_irq));
        check({tag, "_vec"}, 32'(lic_irq_vec), 32'(m_vec));
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  a;
        logic [7:0]  rst_addrs [14];
        int          pulses;
        logic        prev3;
        int          w;

        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", 32'(lic_timer_interrupt), 0);
        check("rst_vec", 32'(lic_irq_vec), 0);
        check("rst_rdata", lic_rdata, 0);
        @(negedge clk);
        resetn = 1'b1;

        // 1: every register reads 0 after reset; free run at presc=0
        rst_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                      8'h40, 8'h44, 8'h48, 8'h4C, 8'h30, 8'hFC};
        foreach (rst_addrs[k]) begin
            bus_rd("rst_reg", rst_addrs[k], v);
            check("rst_reg_zero", v, 0);
        end
        check_out("rst_out");
        bus_wr(8'h00, 32'h1);
        idle(5);
        bus_rd("mtime_run", 8'h04, v);
        check("mtime_is_5", v, 5);

        // 2: prescaler 3 -> one tick per 4 clocks
        bus_wr(8'h00, 0);
        bus_wr(8'h04, 0);
        bus_wr(8'h00, 32'h0301);
        idle(40);
        bus_rd("presc_mtime", 8'h04, v);
        check("presc_rate", 32'(v >= 9 && v <= 11), 1);
        bus_rd("ctrl_rd", 8'h00, v);
        check("ctrl_val", v, 32'h0301);

        // 3: CMP[2]=10 match, interrupt, W1C
        bus_wr(8'h00, 0);
        bus_wr(8'h08, 32'hF);
        bus_wr(8'h04, 0);
        bus_wr(8'h18, 10);
        bus_wr(8'h0C, 32'h4);
        bus_wr(8'h00, 32'h1);
        for (int i = 0; i < 14; i++) begin
            idle(1);
            check_out("cmp2_run");
        end
        bus_rd("cmp2_pend", 8'h08, v);
        check("cmp2_pend_val", v, 32'h4);
        bus_wr(8'h08, 32'h4);
        check_out("w1c_same");
        idle(1);
        check_out("w1c_next");
        check("irq_dropped", 32'(lic_timer_interrupt), 0);

        // 4: wrap match with CMP[0]=0, then W1C colliding with a fresh match
        bus_wr(8'h00, 0);
        bus_wr(8'h08, 32'hF);
        bus_wr(8'h04, 32'hFFFF_FFFE);
        bus_wr(8'h10, 0);
        bus_wr(8'h0C, 32'h1);
        bus_wr(8'h00, 32'h1);
        idle(2);
        bus_rd("wrap_pend", 8'h08, v);
        check("wrap_pend0", 32'(v[0]), 1);
        bus_wr(8'h00, 0);
        bus_wr(8'h04, 32'hFFFF_FFFF);
        bus_wr(8'h00, 32'h1);
        bus_wr(8'h08, 32'h1);
        bus_wr(8'h00, 0);
        bus_rd("setwins_pend", 8'h08, v);
        check("setwins_pend0", 32'(v[0]), 1);
        check_out("setwins_out");

        // 5: EN masks the output, pend still sets
        bus_wr(8'h0C, 0);
        bus_wr(8'h08, 32'hF);
        bus_wr(8'h04, 100);
        bus_wr(8'h14, 103);
        bus_wr(8'h00, 32'h1);
        idle(5);
        bus_wr(8'h00, 0);
        bus_rd("mask_pend", 8'h08, v);
        check("mask_pend_val", v, 32'h2);
        check("mask_irq_low", 32'(lic_timer_interrupt), 0);
        bus_wr(8'h0C, 32'h2);
        idle(1);
        check("unmask_irq", 32'(lic_timer_interrupt), 1);
        check_out("unmask_out");

        // 6: auto-reload (or single shot without it)
        bus_wr(8'h0C, 0);
        bus_wr(8'h08, 32'hF);
        bus_wr(8'h04, 0);
        bus_wr(8'h1C, 4);
        bus_wr(8'h4C, 4);
        bus_wr(8'h0C, 32'h8);
        bus_wr(8'h00, 32'h1);
        pulses = 0;
        prev3  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (m_pend[3]) bus_wr(8'h08, 32'h8);
            else idle(1);
            check_out("reload_run");
            if (lic_irq_vec[3] && !prev3) pulses++;
            prev3 = lic_irq_vec[3];
        end
        bus_wr(8'h00, 0);
        bus_rd("reload_cmp3", 8'h1C, v);
`ifdef LIC_AUTORELOAD_EN
        check("reload_pulses", 32'(pulses), 3);
        check("reload_cmp3_val", v, 16);
        bus_rd("reload_reg3", 8'h4C, v);
        check("reload_reg3_val", v, 4);
`else
        check("reload_pulses", 32'(pulses), 1);
        check("reload_cmp3_val", v, 4);
        bus_rd("reload_reg3", 8'h4C, v);
        check("reload_reg3_val", v, 0);
`endif

        // Asynchronous reset while counting with pending bits live
        bus_wr(8'h0C, 32'hF);
        bus_wr(8'h00, 32'h1);
        idle(3);
        bus_rd("pre_rst_mtime", 8'h04, v);
        resetn = 1'b0;
        #2;
        check("midrst_rdata", lic_rdata, 0);
        check("midrst_irq", 32'(lic_timer_interrupt), 0);
        check("midrst_vec", 32'(lic_irq_vec), 0);
        m_reset();
        @(negedge clk);
        resetn = 1'b1;
        bus_rd("post_rst_pend", 8'h08, v);
        check("post_rst_pend_zero", v, 0);
        bus_rd("post_rst_mtime", 8'h04, v);
        check("post_rst_mtime_zero", v, 0);

        // Random bus traffic against the model
        bus_wr(8'h0C, 32'hF);
        bus_wr(8'h00, 32'h1);
        for (int n = 0; n < 400; n++) begin
            w = $urandom_range(0, 23);
            if ($urandom_range(0, 9) == 0) w = $urandom_range(24, 63);
            a = {6'(w), 2'($urandom_range(0, 3))};
            lic_addr = a;
            lic_cs   = ($urandom_range(0, 2) != 0);
            lic_we   = $urandom_range(0, 1) == 1;
            if (w == 0) lic_wdata = (32'($urandom_range(0, 2)) << 8) | 32'($urandom_range(0, 3) != 0);
            else if (w == 1 || (w >= 4 && w < 8)) lic_wdata = 32'($urandom_range(0, 40));
            else if (w >= 16 && w < 20) lic_wdata = 32'($urandom_range(0, 6));
            else lic_wdata = $urandom;
            cycle();
            check("rand_rdata", lic_rdata, m_rdata);
            check_out("rand");
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
